// File: rtl/clock_generation_sequencer_pkg.sv
// Shared types for the clock-generation sequencer: clock-domain bundle,
// sequencer state and fault-cause encodings.
package common_p;
  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_dom_s;
endpackage

package clks_alot_p;
  typedef enum logic [2:0] {
    SEQ_IDLE          = 3'd0,
    SEQ_CLEAR         = 3'd1,
    SEQ_WAIT_RECOVERY = 3'd2,
    SEQ_INIT          = 3'd3,
    SEQ_ACQUIRE       = 3'd4,
    SEQ_LOCKED        = 3'd5,
    SEQ_FAULT         = 3'd6
  } gen_seq_state_e;

  typedef enum logic [1:0] {
    FC_NONE             = 2'b00,
    FC_RECOVERY_TIMEOUT = 2'b01,
    FC_GEN_TIMEOUT      = 2'b10,
    FC_MISMATCH         = 2'b11
  } gen_seq_fault_e;
endpackage

// File: rtl/clock_generation_sequencer_leaky.sv
// Leaky violation counter: saturating increment on violations, decrement on
// every wrap of a free-running decay timer, and a limit-reached flag.
module leaky_violation_counter #(
  parameter int LIMIT       = 4,
  parameter int DECAY_WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_clk_en,
  input  logic i_srst,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_violation,
  output logic o_limit
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [DECAY_WIDTH-1:0] r_decay;
  logic [CW-1:0]          r_count;
  logic                   w_wrap;

  assign w_wrap = (r_decay == {DECAY_WIDTH{1'b1}});

  // A violation in the same cycle as a decay wrap only increments.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_decay <= '0;
      r_count <= '0;
    end else if (i_clk_en) begin
      if (i_clear) begin
        r_decay <= '0;
        r_count <= '0;
      end else if (i_active) begin
        r_decay <= r_decay + DECAY_WIDTH'(1);
        if (i_violation) begin
          if (r_count != CW'(LIMIT)) r_count <= r_count + CW'(1);
        end else if (w_wrap && (r_count != '0)) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  assign o_limit = (r_count >= CW'(LIMIT));
endmodule

// File: rtl/clock_generation_sequencer.sv
// Bring-up and supervision FSM for one clock_generation instance: ordered
// clear/init/enable sequencing, lock timeouts, mismatch fault and pause gating.
module clock_generation_sequencer
  import clks_alot_p::*;
#(
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_WIDTH  = 16,
  parameter int MISMATCH_LIMIT = 4,
  parameter int DECAY_WIDTH    = 8
) (
  input  common_p::clk_dom_s        sys_dom_i,
  input  logic                      enable_i,
  input  logic                      restart_i,
  input  logic                      polarity_cfg_i,
  input  logic [TIMEOUT_WIDTH-1:0]  lock_timeout_i,
  input  logic                      fully_locked_in_i,
  input  logic                      gen_locked_i,
  input  logic                      delta_mismatch_violation_i,
  input  logic                      pause_start_violation_i,
  input  logic                      pause_stop_violation_i,
  input  logic                      pause_req_i,
  output logic                      clear_state_o,
  output logic                      init_o,
  output logic                      starting_polarity_o,
  output logic                      generation_en_o,
  output logic                      pause_en_o,
  output logic                      pause_ack_o,
  output gen_seq_state_e            state_o,
  output logic                      fault_o,
  output gen_seq_fault_e            fault_cause_o,
  output logic                      pause_violation_o
);
  localparam int CLR_W = $clog2(CLEAR_CYCLES) + 1;

  logic w_clk, w_clk_en, w_srst;
  assign w_clk    = sys_dom_i.clk;
  assign w_clk_en = sys_dom_i.clk_en;
  assign w_srst   = sys_dom_i.sync_rst;

  gen_seq_state_e           r_state, w_state_next;
  gen_seq_fault_e           r_cause, w_cause_next;
  logic [CLR_W-1:0]         r_clr_cnt;
  logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
  logic                     r_polarity, r_pause_en, r_pause_viol;
  logic                     w_expired, w_clr_done, w_mm_limit;

  assign w_expired  = (lock_timeout_i != '0) &&
                      (r_to_cnt == (lock_timeout_i - TIMEOUT_WIDTH'(1)));
  assign w_clr_done = (r_clr_cnt == CLR_W'(CLEAR_CYCLES - 1));

  leaky_violation_counter #(
    .LIMIT       (MISMATCH_LIMIT),
    .DECAY_WIDTH (DECAY_WIDTH)
  ) u_mismatch (
    .i_clk       (w_clk),
    .i_clk_en    (w_clk_en),
    .i_srst      (w_srst),
    .i_clear     (r_state == SEQ_CLEAR),
    .i_active    (r_state == SEQ_LOCKED),
    .i_violation (delta_mismatch_violation_i),
    .o_limit     (w_mm_limit)
  );

  // A lock arriving in the expiry cycle takes precedence over the timeout.
  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    if (!enable_i) begin
      w_state_next = SEQ_IDLE;
    end else begin
      case (r_state)
        SEQ_IDLE:  w_state_next = SEQ_CLEAR;
        SEQ_CLEAR: if (w_clr_done) w_state_next = SEQ_WAIT_RECOVERY;
        SEQ_WAIT_RECOVERY: begin
          if (fully_locked_in_i) begin
            w_state_next = SEQ_INIT;
          end else if (w_expired) begin
            w_state_next = SEQ_FAULT;
            w_cause_next = FC_RECOVERY_TIMEOUT;
          end
        end
        SEQ_INIT: w_state_next = SEQ_ACQUIRE;
        SEQ_ACQUIRE: begin
          if (w_expired && !gen_locked_i) begin
            w_state_next = SEQ_FAULT;
            w_cause_next = FC_GEN_TIMEOUT;
          end else if (!fully_locked_in_i) begin
            w_state_next = SEQ_CLEAR;
          end else if (gen_locked_i) begin
            w_state_next = SEQ_LOCKED;
          end
        end
        SEQ_LOCKED: begin
          if (w_mm_limit) begin
            w_state_next = SEQ_FAULT;
            w_cause_next = FC_MISMATCH;
          end else if (!fully_locked_in_i) begin
            w_state_next = SEQ_CLEAR;
          end else if (!gen_locked_i) begin
            w_state_next = SEQ_ACQUIRE;
          end
        end
        SEQ_FAULT: if (restart_i) w_state_next = SEQ_CLEAR;
        default:   w_state_next = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_srst) begin
      r_state <= SEQ_IDLE;
      r_cause <= FC_NONE;
    end else if (w_clk_en) begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
    end
  end

  // Phase counters restart whenever the state changes.
  always_ff @(posedge w_clk) begin
    if (w_srst) begin
      r_clr_cnt    <= '0;
      r_to_cnt     <= '0;
      r_polarity   <= 1'b0;
      r_pause_en   <= 1'b0;
      r_pause_viol <= 1'b0;
    end else if (w_clk_en) begin
      r_clr_cnt <= (r_state == SEQ_CLEAR && w_state_next == SEQ_CLEAR) ?
                   r_clr_cnt + CLR_W'(1) : '0;
      r_to_cnt  <= ((w_state_next == r_state) &&
                    (r_state == SEQ_WAIT_RECOVERY || r_state == SEQ_ACQUIRE)) ?
                   r_to_cnt + TIMEOUT_WIDTH'(1) : '0;
      if (w_state_next == SEQ_IDLE || w_state_next == SEQ_FAULT)
        r_polarity <= 1'b0;
      else if (w_state_next == SEQ_INIT)
        r_polarity <= polarity_cfg_i;
      r_pause_en <= (w_state_next == SEQ_LOCKED) && pause_req_i;
      if (r_state == SEQ_CLEAR)
        r_pause_viol <= 1'b0;
      else if (pause_start_violation_i || pause_stop_violation_i)
        r_pause_viol <= 1'b1;
    end
  end

  assign state_o             = r_state;
  assign clear_state_o       = (r_state == SEQ_CLEAR);
  assign init_o              = (r_state == SEQ_INIT);
  assign generation_en_o     = (r_state == SEQ_ACQUIRE) || (r_state == SEQ_LOCKED);
  assign starting_polarity_o = r_polarity;
  assign pause_en_o          = r_pause_en;
  assign pause_ack_o         = r_pause_en;
  assign fault_o             = (r_state == SEQ_FAULT);
  assign fault_cause_o       = r_cause;
  assign pause_violation_o   = r_pause_viol;
endmodule

// File: tb/tb_clock_generation_sequencer.sv
// Self-checking bench: directed scenarios plus randomized stimulus, compared
// every cycle against a behavioural model of the sequencing rules.
module tb_clock_generation_sequencer;
  import clks_alot_p::*;

  logic clk, clk_en, rst;
  logic enable, restart, pol_cfg, fl, gl, dmv, psv, pev, preq;
  logic [15:0] timeout;
  common_p::clk_dom_s sys_dom;

  logic clear_o, init_o, pol_o, gen_o, pause_o, ack_o, fault_o, pviol_o;
  gen_seq_state_e state_o;
  gen_seq_fault_e cause_o;

  int tests_run = 0;
  int tests_failed = 0;

  assign sys_dom = {clk, clk_en, rst};

  clock_generation_sequencer dut (
    .sys_dom_i                  (sys_dom),
    .enable_i                   (enable),
    .restart_i                  (restart),
    .polarity_cfg_i             (pol_cfg),
    .lock_timeout_i             (timeout),
    .fully_locked_in_i          (fl),
    .gen_locked_i               (gl),
    .delta_mismatch_violation_i (dmv),
    .pause_start_violation_i    (psv),
    .pause_stop_violation_i     (pev),
    .pause_req_i                (preq),
    .clear_state_o              (clear_o),
    .init_o                     (init_o),
    .starting_polarity_o        (pol_o),
    .generation_en_o            (gen_o),
    .pause_en_o                 (pause_o),
    .pause_ack_o                (ack_o),
    .state_o                    (state_o),
    .fault_o                    (fault_o),
    .fault_cause_o              (cause_o),
    .pause_violation_o          (pviol_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: phase lengths are counted as completed cycles.
  gen_seq_state_e m_state;
  gen_seq_fault_e m_cause;
  int m_clr, m_phase, m_mm, m_lk;
  bit m_pol, m_pause, m_pviol;

  task automatic chk(string name, int act, int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    gen_seq_state_e prev, nxt;
    bit expired, wrap;
    if (rst) begin
      m_state = SEQ_IDLE; m_cause = FC_NONE;
      m_clr = 0; m_phase = 0; m_mm = 0; m_lk = 0;
      m_pol = 0; m_pause = 0; m_pviol = 0;
      return;
    end
    if (!clk_en) return;
    prev = m_state;
    expired = (timeout != 0) && ((m_phase % 65536) == int'(timeout) - 1);
    nxt = prev;
    if (!enable) nxt = SEQ_IDLE;
    else begin
      case (prev)
        SEQ_IDLE:          nxt = SEQ_CLEAR;
        SEQ_CLEAR:         nxt = (m_clr + 1 >= 2) ? SEQ_WAIT_RECOVERY : SEQ_CLEAR;
        SEQ_WAIT_RECOVERY: nxt = fl ? SEQ_INIT : (expired ? SEQ_FAULT : prev);
        SEQ_INIT:          nxt = SEQ_ACQUIRE;
        SEQ_ACQUIRE:
          if (expired && !gl) nxt = SEQ_FAULT;
          else if (!fl) nxt = SEQ_CLEAR;
          else if (gl) nxt = SEQ_LOCKED;
        SEQ_LOCKED:
          if (m_mm >= 4) nxt = SEQ_FAULT;
          else if (!fl) nxt = SEQ_CLEAR;
          else if (!gl) nxt = SEQ_ACQUIRE;
        SEQ_FAULT:         nxt = restart ? SEQ_CLEAR : prev;
        default:           nxt = SEQ_IDLE;
      endcase
    end
    if (nxt == SEQ_FAULT && prev != SEQ_FAULT)
      m_cause = (prev == SEQ_WAIT_RECOVERY) ? FC_RECOVERY_TIMEOUT :
                (prev == SEQ_ACQUIRE) ? FC_GEN_TIMEOUT : FC_MISMATCH;
    m_clr = (prev == SEQ_CLEAR && nxt == SEQ_CLEAR) ? m_clr + 1 : 0;
    m_phase = (nxt == prev && (prev == SEQ_WAIT_RECOVERY || prev == SEQ_ACQUIRE)) ?
              m_phase + 1 : 0;
    if (prev == SEQ_CLEAR) begin
      m_mm = 0; m_lk = 0;
    end else if (prev == SEQ_LOCKED) begin
      wrap = (m_lk % 256) == 255;
      m_lk++;
      if (dmv) m_mm = (m_mm < 4) ? m_mm + 1 : 4;
      else if (wrap && m_mm > 0) m_mm--;
    end
    if (prev == SEQ_CLEAR) m_pviol = 0;
    else if (psv || pev) m_pviol = 1;
    if (nxt == SEQ_IDLE || nxt == SEQ_FAULT) m_pol = 0;
    else if (nxt == SEQ_INIT) m_pol = pol_cfg;
    m_pause = (nxt == SEQ_LOCKED) && preq;
    m_state = nxt;
  endtask

  task automatic compare();
    chk("state", int'(state_o), int'(m_state));
    chk("clear_state", int'(clear_o), int'(m_state == SEQ_CLEAR));
    chk("init", int'(init_o), int'(m_state == SEQ_INIT));
    chk("gen_en", int'(gen_o), int'(m_state == SEQ_ACQUIRE || m_state == SEQ_LOCKED));
    chk("fault", int'(fault_o), int'(m_state == SEQ_FAULT));
    chk("cause", int'(cause_o), int'(m_cause));
    chk("pause_en", int'(pause_o), int'(m_pause));
    chk("pause_ack", int'(ack_o), int'(m_pause));
    chk("polarity", int'(pol_o), int'(m_pol));
    chk("pause_viol", int'(pviol_o), int'(m_pviol));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic wait_state(gen_seq_state_e target, int max, string name);
    for (int i = 0; i < max; i++) begin
      if (state_o == target) break;
      cycle();
    end
    chk(name, int'(state_o), int'(target));
  endtask

  task automatic do_reset();
    enable = 0; restart = 0; pol_cfg = 0; fl = 0; gl = 0;
    dmv = 0; psv = 0; pev = 0; preq = 0; timeout = 0;
    clk_en = 1; rst = 1;
    cycle(); cycle();
    rst = 0;
  endtask

  task automatic bring_up();
    enable = 1; fl = 1; gl = 1; timeout = 0;
    wait_state(SEQ_LOCKED, 20, "bring_up_locked");
  endtask

  initial begin
    int n_clear, n_init, n_wr, n_acq;
    do_reset();
    chk("rst_state", int'(state_o), int'(SEQ_IDLE));
    chk("rst_outs", int'({clear_o, init_o, pol_o, gen_o, pause_o, fault_o, pviol_o}), 0);
    chk("rst_cause", int'(cause_o), 0);

    // Bring-up timeline
    n_clear = 0; n_init = 0; pol_cfg = 1;
    for (int c = 0; c < 22; c++) begin
      enable = 1; fl = (c >= 10); gl = (c >= 20);
      cycle();
      n_clear += int'(clear_o); n_init += int'(init_o);
      if (c == 20) chk("locked_at_20", int'(state_o), int'(SEQ_LOCKED));
    end
    chk("clear_len", n_clear, 2);
    chk("init_len", n_init, 1);
    chk("pol_cfg", int'(pol_o), 1);

    // Recovery timeout
    do_reset();
    timeout = 8; enable = 1; n_wr = 0;
    for (int i = 0; i < 30 && state_o != SEQ_FAULT; i++) begin
      cycle();
      if (state_o == SEQ_WAIT_RECOVERY) n_wr++;
    end
    chk("rto_fault", int'(fault_o), 1);
    chk("rto_wr_cycles", n_wr, 8);
    chk("rto_cause", int'(cause_o), 1);
    restart = 1; cycle(); restart = 0;
    chk("restart_clear", int'(clear_o), 1);
    chk("restart_cause", int'(cause_o), 1);

    // Spaced mismatches decay; a burst faults
    do_reset(); bring_up();
    for (int k = 0; k < 3; k++) begin
      dmv = 1; cycle(); dmv = 0;
      repeat (300) cycle();
    end
    chk("spaced_locked", int'(state_o), int'(SEQ_LOCKED));
    dmv = 1; repeat (4) cycle(); dmv = 0;
    wait_state(SEQ_FAULT, 10, "burst_fault");
    chk("burst_cause", int'(cause_o), 3);

    // Lock loss while paused
    do_reset(); bring_up();
    preq = 1; repeat (3) cycle();
    chk("paused", int'(pause_o), 1);
    timeout = 5; gl = 0; cycle();
    chk("loss_acq", int'(state_o), int'(SEQ_ACQUIRE));
    chk("loss_unpause", int'(pause_o), 0);
    n_acq = 1;
    for (int i = 0; i < 20 && state_o != SEQ_FAULT; i++) begin
      cycle();
      if (state_o == SEQ_ACQUIRE) n_acq++;
    end
    chk("acq_restart_len", n_acq, 5);
    chk("gen_to_cause", int'(cause_o), 2);
    preq = 0;

    // Recovery loss, clk_en freeze mid-CLEAR
    do_reset(); bring_up();
    fl = 0; cycle();
    chk("rloss_clear", int'(clear_o), 1);
    n_clear = 1;
    clk_en = 0;
    repeat (5) begin
      cycle();
      chk("frozen_clear", int'(state_o), int'(SEQ_CLEAR));
    end
    clk_en = 1;
    cycle(); n_clear += int'(clear_o);
    cycle(); n_clear += int'(clear_o);
    chk("clear_enabled_len", n_clear, 2);
    chk("after_clear_wr", int'(state_o), int'(SEQ_WAIT_RECOVERY));

    // Reset during ACQUIRE, with clk_en low
    do_reset();
    enable = 1; fl = 1; gl = 0;
    wait_state(SEQ_ACQUIRE, 20, "reach_acq");
    rst = 1; clk_en = 0; cycle(); rst = 0; clk_en = 1;
    chk("rst_acq_state", int'(state_o), int'(SEQ_IDLE));
    chk("rst_acq_outs", int'({clear_o, init_o, gen_o, pause_o, fault_o}), 0);

    // Lock coincides with timeout expiry
    do_reset();
    timeout = 3; enable = 1; fl = 1; gl = 0;
    wait_state(SEQ_INIT, 20, "reach_init");
    repeat (3) cycle();
    gl = 1; cycle();
    chk("lock_beats_expiry", int'(state_o), int'(SEQ_LOCKED));

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (i % 50 == 0) timeout = 16'($urandom_range(0, 12));
      rst     = ($urandom_range(0, 499) == 0);
      clk_en  = ($urandom_range(0, 99) < 85);
      enable  = ($urandom_range(0, 99) < 97);
      restart = ($urandom_range(0, 99) < 10);
      pol_cfg = 1'($urandom_range(0, 1));
      fl      = ($urandom_range(0, 99) < 93);
      gl      = ($urandom_range(0, 99) < 80);
      dmv     = ($urandom_range(0, 99) < 3);
      psv     = ($urandom_range(0, 99) < 1);
      pev     = ($urandom_range(0, 99) < 1);
      preq    = ($urandom_range(0, 99) < 50);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/clock_generation_sequencer.md
# clock_generation_sequencer

Control FSM that brings up and supervises one `clock_generation` instance. It drives that instance's `clear_state_i`, `init_i`, `starting_polarity_i`, `generation_en_i` and `pause_en_i` in order, gated by recovery lock (`fully_locked_in`) and generator delta lock. It watches `delta_mismatch_violation_o` through a leaky counter and raises a latched fault on timeout or repeated mismatch.

## Interface
- `CLEAR_CYCLES`, default 2: enabled cycles `clear_state_o` is held.
- `TIMEOUT_WIDTH`, default 16: width of the lock-timeout counter and `lock_timeout_i`.
- `MISMATCH_LIMIT`, default 4: leaky-counter value that triggers a mismatch fault.
- `DECAY_WIDTH`, default 8: mismatch count decays by 1 every 2^DECAY_WIDTH enabled cycles.

Ports (name, direction, width, meaning):
- `sys_dom_i`, in, `common_p::clk_dom_s`: carries `clk` (single clock), `clk_en`, and `sync_rst` (synchronous, active-high reset).
- `enable_i`, in, 1: run request; low forces IDLE.
- `restart_i`, in, 1: leave FAULT.
- `polarity_cfg_i`, in, 1: starting polarity, captured on INIT entry.
- `lock_timeout_i`, in, TIMEOUT_WIDTH: per-phase timeout in enabled cycles; 0 disables the timeout.
- `fully_locked_in_i`, in, 1: recovery lock.
- `gen_locked_i`, in, 1: `unpausable_clk_state.status.locked` from the generator.
- `delta_mismatch_violation_i`, `pause_start_violation_i`, `pause_stop_violation_i`, in, 1 each: generator violation pulses.
- `pause_req_i`, in, 1: level-sensitive pause request.
- `clear_state_o`, `init_o`, `starting_polarity_o`, `generation_en_o`, `pause_en_o`, out, 1 each: drive the generator.
- `pause_ack_o`, out, 1: equals `pause_en_o`.
- `state_o`, out, `clks_alot_p::gen_seq_state_e`: current state.
- `fault_o`, out, 1: high while in FAULT.
- `fault_cause_o`, out, `clks_alot_p::gen_seq_fault_e`: cause of the last fault.
- `pause_violation_o`, out, 1: sticky flag for any pause violation.

## Operation
- States: IDLE, CLEAR, WAIT_RECOVERY, INIT, ACQUIRE, LOCKED, FAULT.
- Reset values: state IDLE; all outputs 0; fault cause NONE (2'b00); all counters 0.
- State updates occur only when `clk_en` is high. `sync_rst` acts regardless of `clk_en`.
- Transition priority: `sync_rst` > `!enable_i` (go to IDLE) > `restart_i` in FAULT > fault conditions > lock loss > normal progression.
- **IDLE:** `enable_i` -> CLEAR.
- **CLEAR:**
  - `clear_state_o` = 1 for exactly CLEAR_CYCLES enabled cycles, then go to WAIT_RECOVERY.
  - Clears the timeout counter, mismatch counter, decay timer and `pause_violation_o`.
- **WAIT_RECOVERY:**
  - `fully_locked_in_i` -> INIT.
  - Timeout expiry -> FAULT with cause RECOVERY_TIMEOUT (2'b01).
- **INIT:** one cycle. `init_o` = 1 and `starting_polarity_o` <= `polarity_cfg_i`; the polarity holds until the next INIT. Then go to ACQUIRE.
- **ACQUIRE:**
  - `generation_en_o` = 1.
  - `gen_locked_i` -> LOCKED.
  - Timeout expiry -> FAULT with cause GEN_TIMEOUT (2'b10).
  - `!fully_locked_in_i` -> CLEAR.
- **LOCKED:**
  - `generation_en_o` = 1.
  - `!gen_locked_i` -> ACQUIRE; the timeout counter restarts.
  - `!fully_locked_in_i` -> CLEAR.
  - Mismatch count reaching MISMATCH_LIMIT -> FAULT with cause MISMATCH (2'b11).
- **Mismatch counter:** active in LOCKED only.
  - Increments by 1 on `delta_mismatch_violation_i` and saturates at MISMATCH_LIMIT.
  - Decrements by 1 (floor 0) when the decay timer wraps.
  - Violation and decay wrap in the same cycle: increment only.
- **Pause:** allowed in LOCKED only.
  - `pause_en_o` follows `pause_req_i` with one enabled cycle of latency.
  - Any exit from LOCKED forces `pause_en_o` to 0 on the transition cycle.
  - A request outside LOCKED is held off until LOCKED is entered.
- **`pause_violation_o`:** set on either pause violation pulse; cleared in CLEAR and on reset.
- **FAULT:**
  - All generator controls are 0; `fault_o` = 1.
  - `fault_cause_o` holds until the next fault or reset.
  - `restart_i` -> CLEAR.
- **Timeout counter:** counts enabled cycles in WAIT_RECOVERY and ACQUIRE and is cleared on entry to each. Expiry is count == `lock_timeout_i` - 1, with `lock_timeout_i` != 0.
  - Lock and expiry in the same cycle: lock wins.

## Timing
- All outputs are registered from state or counters; there are no combinational input-to-output paths.
- From `enable_i` rising to `clear_state_o` high: 1 enabled cycle.
- From `fully_locked_in_i` to `init_o`: 1 cycle. `generation_en_o` rises the cycle after `init_o`.
- `clk_en` low freezes the state and all counters; outputs hold.
- `!enable_i` mid-operation: the next enabled cycle reaches IDLE with all outputs 0. `fault_cause_o` is kept.

## Structure
- In `clks_alot_p`:
  - `gen_seq_state_e`, 3-bit enum.
  - `gen_seq_fault_e`, 2-bit enum with values NONE, RECOVERY_TIMEOUT, GEN_TIMEOUT, MISMATCH.
- Sub-module `leaky_violation_counter`: saturating increment, periodic decay, and a limit flag. Parameters are the limit and the decay width.

## Test plan
- Bring-up: `enable_i`, then `fully_locked_in_i` at cycle 10, then `gen_locked_i` at cycle 20.
  - Required: `clear_state_o` for 2 cycles, `init_o` exactly 1 cycle, `starting_polarity_o` = cfg, LOCKED by cycle 21.
- Recovery timeout: `lock_timeout_i` = 8 and recovery never locks.
  - Required: FAULT, cause 2'b01, after 8 WAIT_RECOVERY cycles.
  - Then `restart_i` -> CLEAR, and `fault_cause_o` still reads 2'b01.
- Mismatch: 4 violations within 10 cycles in LOCKED -> FAULT, cause 2'b11.
  - With 3 violations spaced more than 256 cycles apart, the sequencer stays LOCKED.
- Lock loss: drop `gen_locked_i` while paused.
  - Required: `pause_en_o` falls on the transition, state goes to ACQUIRE, and the timeout restarts.
- Recovery loss in LOCKED -> CLEAR with `clear_state_o` asserted. Hold `clk_en` low for 5 cycles mid-CLEAR: state frozen, `clear_state_o` still lasts 2 enabled cycles in total.
- Same-cycle conflicts:
  - `sync_rst` during ACQUIRE -> all outputs 0 on the next cycle.
  - Lock and timeout expiry in the same cycle -> LOCKED, not FAULT.
